spi_target: RTL and testbench

- SPI target (peripheral) endpoint that answers the codebase's SPI controller over sclk/ss_n/mosi/miso.
- Oversamples the asynchronous SPI pins in the system clock domain and supports all four cpol/cpha modes.
- Transfers are 8-bit and LSB-first. The block receives mosi bytes and transmits miso bytes from a one-entry tx buffer.
- Frames of any byte count are delimited by ss_n.

---
 rtl/spi_target.sv | 175 +++++++++++++++++
 tb/tb_spi_target.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// spi_target: SPI peripheral endpoint, all four cpol/cpha modes, LSB-first bytes,
// pins oversampled in the clk domain, one-entry tx buffer.
`default_nettype none

module spi_target #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              sclk,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_underrun,
   output logic              frame_done,
   output logic              frame_active
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
   logic                   sclk_d, ss_d;
   logic                   sclk_s, ss_s, mosi_s;
   logic                   cpol_l, cpha_l, skip, reload, buf_full, rx_done;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_W-2:0]      rx_shift;
   logic [DATA_W-1:0]      rx_next, tx_shift, buf_data, load_val;
   logic                   ss_fall, ss_rise, sclk_edge, leading, trailing;
   logic                   start, stop, sample, shift, pop, push;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // ss_n synchronizer clears to 0 so a release with ss_n still low never fakes a frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         ss_sync   <= '0;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_s;
         ss_d      <= ss_s;
      end
   end

   assign ss_fall   = ss_d & ~ss_s;
   assign ss_rise   = ~ss_d & ss_s;
   assign sclk_edge = sclk_s ^ sclk_d;
   assign leading   = sclk_edge & (sclk_d == cpol_l);
   assign trailing  = sclk_edge & (sclk_s == cpol_l);

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      stop      = 1'b0;
      sample    = 1'b0;
      shift     = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) begin
               state_nxt = ACTIVE;
               start     = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_nxt = IDLE;
               stop      = 1'b1;
            end else if (sclk_edge) begin
               sample = cpha_l ? trailing : leading;
               shift  = cpha_l ? leading  : trailing;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign pop      = start | (shift & ~skip & reload);
   assign push     = tx_valid & ~buf_full;
   assign load_val = buf_full ? buf_data : '0;
   assign rx_next  = {mosi_s, rx_shift};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cpol_l      <= 1'b0;
         cpha_l      <= 1'b0;
         skip        <= 1'b0;
         reload      <= 1'b0;
         bit_cnt     <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         rx_data     <= '0;
         rx_done     <= 1'b0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_done  <= 1'b0;
         buf_full    <= 1'b0;
         buf_data    <= '0;
      end else begin
         state       <= state_nxt;
         rx_done     <= 1'b0;
         rx_valid    <= rx_done;
         tx_underrun <= 1'b0;
         frame_done  <= stop;

         // a pop on an empty buffer still lets a same-cycle push fill it
         if (pop && buf_full) begin
            buf_full <= 1'b0;
         end else if (push) begin
            buf_full <= 1'b1;
            buf_data <= tx_data;
         end

         if (pop) begin
            tx_shift    <= load_val;
            tx_underrun <= ~buf_full;
         end else if (shift && !skip) begin
            tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
         end

         if (start) begin
            cpol_l  <= cpol;
            cpha_l  <= cpha;
            bit_cnt <= '0;
            skip    <= cpha;
            reload  <= 1'b0;
         end else if (shift) begin
            if (skip)
               skip <= 1'b0;
            else if (reload)
               reload <= 1'b0;
         end

         if (sample) begin
            rx_shift <= rx_next[DATA_W-1:1];
            if (bit_cnt == LAST_BIT) begin
               bit_cnt <= '0;
               rx_data <= rx_next;
               rx_done <= 1'b1;
               reload  <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   assign miso         = tx_shift[0];
   assign miso_oe      = (state == ACTIVE);
   assign frame_active = (state == ACTIVE);
   assign tx_ready     = ~buf_full;

endmodule

`default_nettype wire

// File: tb/tb_spi_target.sv
// tb_spi_target: drives spi_target as an SPI controller and compares against a
// byte-level model of the tx buffer and frame traffic.
`default_nettype none

module tb_spi_target;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_done, frame_active;
   logic [7:0] rx_data;

   spi_target #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n),
      .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
      .frame_done(frame_done), .frame_active(frame_active)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int n_fd = 0, n_und = 0;
   logic [7:0] rxq[$];
   logic [7:0] feed[$];
   logic [7:0] model_q[$];
   logic [7:0] mo[0:7];
   logic [7:0] mi[0:7];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid) rxq.push_back(rx_data);
      if (frame_done) n_fd++;
      if (tx_underrun) n_und++;
   end

   // hands queued bytes to the DUT whenever its buffer is empty
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && tx_ready && feed.size() > 0) begin
            tx_data  = feed.pop_front();
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
         end
      end
   end

   task automatic give(input logic [7:0] b);
      feed.push_back(b);
      model_q.push_back(b);
   endtask

   task automatic settle();
      int i;
      for (i = 0; i < 50; i++) begin
         if (feed.size() == 0 || !tx_ready) break;
         @(negedge clk);
      end
      if (i == 50) check("feed_timeout", 1, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic spi_xfer(input bit pol, input bit pha, input int nbits, input int hp, input bit abort);
      cpol = pol; cpha = pha; sclk = pol;
      repeat (hp) @(negedge clk);
      ss_n = 1'b0;
      if (!pha) mosi = mo[0][0];
      repeat (hp) @(negedge clk);
      for (int b = 0; b < nbits; b++) begin
         if (pha) mosi = mo[b/8][b%8];
         else     mi[b/8][b%8] = miso;
         sclk = ~pol;
         repeat (hp) @(negedge clk);
         if (b == 0) check("active_oe", {frame_active, miso_oe}, 2'b11);
         if (pha) mi[b/8][b%8] = miso;
         if (!(abort && !pha && b == nbits - 1)) begin
            sclk = pol;
            if (!pha && b + 1 < nbits) mosi = mo[(b+1)/8][(b+1)%8];
            repeat (hp) @(negedge clk);
         end
      end
      ss_n = 1'b1;
      repeat (hp) @(negedge clk);
      sclk = pol;
      repeat (hp + 4) @(negedge clk);
      check("idle_oe", {frame_active, miso_oe}, 2'b00);
   endtask

   // byte-level model: every load takes the oldest queued byte or 0x00 with an underrun;
   // a cpha=0 frame reloads after each byte, a cpha=1 frame only between bytes
   task automatic run_frame(input bit pol, input bit pha, input int nbytes, input int hp);
      logic [7:0] expm[0:7];
      int rx0, fd0, und0, loads, exp_und;
      settle();
      rx0 = rxq.size(); fd0 = n_fd; und0 = n_und;
      loads = 1 + (pha ? nbytes - 1 : nbytes);
      exp_und = 0;
      for (int i = 0; i < loads; i++) begin
         logic [7:0] v;
         if (model_q.size() > 0) v = model_q.pop_front();
         else begin v = 8'h00; exp_und++; end
         if (i < nbytes) expm[i] = v;
      end
      spi_xfer(pol, pha, 8 * nbytes, hp, 1'b0);
      check("rx_count", rxq.size() - rx0, nbytes);
      for (int i = 0; i < nbytes; i++) begin
         if (rx0 + i < rxq.size()) check("rx_byte", rxq[rx0 + i], mo[i]);
         check("miso_byte", mi[i], expm[i]);
      end
      check("frame_done", n_fd - fd0, 1);
      check("underruns", n_und - und0, exp_und);
      settle();
      check("tx_ready", tx_ready, model_q.size() == 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

   initial begin
      int rx0, fd0, und0;
      logic oe_seen;
      repeat (3) @(negedge clk);
      check("rst_outs", {miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_done, frame_active},
            7'b0010000);
      check("rst_rx_data", rx_data, 8'h00);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // mode 0 single byte
      give(8'hA5); mo[0] = 8'h3C;
      run_frame(1'b0, 1'b0, 1, 4);
      check("t1_rx_data", rx_data, 8'h3C);

      // mode 3 two bytes, refilled while active
      give(8'h81); give(8'h7E); mo[0] = 8'h12; mo[1] = 8'h34;
      run_frame(1'b1, 1'b1, 2, 4);

      // mode 1 with empty buffer
      mo[0] = 8'hFF;
      run_frame(1'b0, 1'b1, 1, 5);
      check("t3_rx_data", rx_data, 8'hFF);

      // abort after 5 sample edges, then a clean frame
      for (int m = 0; m < 2; m++) begin
         settle();
         rx0 = rxq.size(); fd0 = n_fd;
         if (model_q.size() > 0) void'(model_q.pop_front());
         mo[0] = 8'hE7;
         spi_xfer(1'b0, m[0], 5, 4, 1'b1);
         check("abort_rx", rxq.size() - rx0, 0);
         check("abort_fd", n_fd - fd0, 1);
         mo[0] = 8'h5A;
         run_frame(1'b0, m[0], 1, 4);
         check("after_abort_rx", rx_data, 8'h5A);
      end

      // sclk toggling while deselected
      give(8'h96);
      settle();
      rx0 = rxq.size(); fd0 = n_fd; oe_seen = 1'b0;
      cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sclk = ~sclk;
         repeat (4) @(negedge clk);
         oe_seen = oe_seen | miso_oe;
      end
      repeat (6) @(negedge clk);
      check("idle_sclk_rx", rxq.size() - rx0, 0);
      check("idle_sclk_fd", n_fd - fd0, 0);
      check("idle_sclk_oe", oe_seen, 1'b0);
      check("idle_sclk_keep", tx_ready, 1'b0);
      mo[0] = 8'h0F;
      run_frame(1'b0, 1'b0, 1, 4);

      // reset mid-frame with a byte buffered
      settle();
      cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
      repeat (4) @(negedge clk);
      ss_n = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         sclk = ~sclk;
         mosi = i[1];
         repeat (4) @(negedge clk);
      end
      give(8'hC3);
      repeat (6) @(negedge clk);
      check("pre_rst_full", tx_ready, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      feed.delete(); model_q.delete();
      check("mid_rst_outs", {miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_done, frame_active},
            7'b0010000);
      check("mid_rst_rx_data", rx_data, 8'h00);
      rst_n = 1'b1;
      fd0 = n_fd;
      repeat (5) @(negedge clk);
      ss_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_fd", n_fd - fd0, 0);
      und0 = n_und;
      mo[0] = 8'h6B;
      run_frame(1'b0, 1'b0, 1, 4);
      check("post_rst_underrun", (n_und - und0) > 0, 1'b1);

      // randomized frames
      for (int f = 0; f < 12; f++) begin
         int nb, np;
         bit pol, pha;
         pol = 1'($urandom_range(0, 1));
         pha = 1'($urandom_range(0, 1));
         nb = $urandom_range(1, 3);
         np = $urandom_range(0, nb + 1);
         for (int i = 0; i < np; i++) give(8'($urandom));
         for (int i = 0; i < nb; i++) mo[i] = 8'($urandom);
         run_frame(pol, pha, nb, $urandom_range(4, 6));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
